// File: rtl/rf_write_sequencer.sv
// rf_write_sequencer: buffers register-file write requests in a small FIFO,
// issues at most one registered write per cycle, and runs a bulk CLEAR that
// zeroes every register one per cycle.
module rf_write_sequencer #(
  parameter int unsigned W     = 3,
  parameter int unsigned NREG  = 3,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic [W-1:0]    req_data,
  input  logic            clr_start,
  output logic [W-1:0]    wr_din,
  output logic [NREG-1:0] wr_sel,
  output logic [2:0]      count,
  output logic            busy,
  output logic            err_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [IW-1:0]   clr_idx_q, clr_idx_d;
  logic [W-1:0]    wr_din_q, wr_din_d;
  logic [NREG-1:0] wr_sel_q, wr_sel_d;
  logic            err_q, err_d;
  logic            push, pop;
  req_t            mem_q [DEPTH];
  req_t            head;

  // Ready reflects pre-edge occupancy, so a push can never hit a full FIFO.
  assign req_ready = reset & (count_q != CW'(DEPTH));
  assign push      = req_valid & req_ready;
  assign head      = mem_q[rd_q];

  assign wr_din   = wr_din_q;
  assign wr_sel   = wr_sel_q;
  assign count    = count_q;
  assign err_addr = err_q;
  assign busy     = (state_q == CLEAR) | (count_q != '0);

  // FIFO storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= '{addr: req_addr, data: req_data};
    end
  end

  // State, pointers, occupancy and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      clr_idx_q <= '0;
      wr_din_q  <= '0;
      wr_sel_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      clr_idx_q <= clr_idx_d;
      wr_din_q  <= wr_din_d;
      wr_sel_q  <= wr_sel_d;
      err_q     <= err_d;
    end
  end

  // Next-state and output decode; a clr_start in DRAIN suppresses that cycle's pop.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_din_d  = '0;
    wr_sel_d  = '0;
    err_d     = err_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    pop       = 1'b0;

    if (state_q == DRAIN && !clr_start && count_q != '0) begin
      pop = 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      wr_d = wr_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (push) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (clr_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (pop) begin
          rd_d     = rd_q + PW'(1);
          wr_din_d = head.data;
          if (32'(head.addr) < NREG) begin
            wr_sel_d = NREG'(1) << head.addr;
          end else begin
            err_d = 1'b1;
          end
          if (count_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      CLEAR: begin
        wr_sel_d  = NREG'(1) << clr_idx_q;
        clr_idx_d = clr_idx_q + IW'(1);
        if (clr_idx_q == IW'(NREG - 1)) begin
          clr_idx_d = '0;
          state_d   = (count_d != '0) ? DRAIN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a queue-based model.
module tb_rf_write_sequencer;

  localparam int W     = 3;
  localparam int NREG  = 3;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [W-1:0]    req_data;
  logic            clr_start;
  logic [W-1:0]    wr_din;
  logic [NREG-1:0] wr_sel;
  logic [2:0]      count;
  logic            busy;
  logic            err_addr;

  rf_write_sequencer #(.W(W), .NREG(NREG), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_data (req_data),
    .clr_start(clr_start),
    .wr_din   (wr_din),
    .wr_sel   (wr_sel),
    .count    (count),
    .busy     (busy),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue of pending requests plus a count of clear steps left.
  typedef struct { int a; int d; } ent_t;
  ent_t q[$];
  int   clr_left = 0;
  int   m_sel = 0, m_din = 0, m_err = 0;

  typedef struct {
    bit r, v; int a, d; bit c;
    int sel, din, cnt, rdy, bsy, err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input int a, input int d, input bit c);
    bit   pu;
    ent_t e;
    if (!r) begin
      q.delete();
      clr_left = 0; m_sel = 0; m_din = 0; m_err = 0;
    end else begin
      pu = v && (q.size() < DEPTH);
      m_sel = 0; m_din = 0;
      if (clr_left > 0) begin
        m_sel = 1 << (NREG - clr_left);
        clr_left--;
      end else if (c) begin
        clr_left = NREG;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_din = e.d;
        if (e.a < NREG) m_sel = 1 << e.a;
        else m_err = 1;
      end
      if (pu) q.push_back('{a: a, d: d});
    end
  endtask

  task automatic check_model();
    chk("wr_sel", int'(wr_sel), m_sel);
    chk("wr_din", int'(wr_din), m_din);
    chk("count", int'(count), q.size());
    chk("req_ready", int'(req_ready), (reset && q.size() < DEPTH) ? 1 : 0);
    chk("busy", int'(busy), (clr_left > 0 || q.size() > 0) ? 1 : 0);
    chk("err_addr", int'(err_addr), m_err);
  endtask

  // Drive on the falling edge, update the model at the rising edge, sample 1 later.
  task automatic step(input bit r, input bit v, input int a, input int d, input bit c,
                      input bit use_model);
    @(negedge clk);
    reset = r; req_valid = v; req_addr = AW'(a); req_data = W'(d); clr_start = c;
    @(posedge clk);
    model_edge(r, v, a, d, c);
    #1;
    if (use_model) check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 1);
  endtask

  vec_t vt[13];

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; clr_start = 1'b0;

    //        r  v  a  d  c   sel din cnt rdy bsy err
    vt[0]  = '{0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0};
    vt[1]  = '{0, 1, 2, 5, 0,  0,  0,  0,  0,  0,  0};
    vt[2]  = '{1, 1, 2, 5, 0,  0,  0,  1,  1,  1,  0};
    vt[3]  = '{1, 0, 0, 0, 0,  4,  5,  0,  1,  0,  0};
    vt[4]  = '{1, 0, 0, 0, 0,  0,  0,  0,  1,  0,  0};
    vt[5]  = '{1, 1, 3, 6, 0,  0,  0,  1,  1,  1,  0};
    vt[6]  = '{1, 0, 0, 0, 0,  0,  6,  0,  1,  0,  1};
    vt[7]  = '{1, 1, 0, 3, 0,  0,  0,  1,  1,  1,  1};
    vt[8]  = '{1, 0, 0, 0, 0,  1,  3,  0,  1,  0,  1};
    vt[9]  = '{1, 1, 1, 7, 0,  0,  0,  1,  1,  1,  1};
    vt[10] = '{1, 1, 2, 2, 0,  2,  7,  1,  1,  1,  1};
    vt[11] = '{1, 0, 0, 0, 0,  4,  2,  0,  1,  0,  1};
    vt[12] = '{1, 0, 0, 0, 0,  0,  0,  0,  1,  0,  1};

    for (int i = 0; i < 13; i++) begin
      step(vt[i].r, vt[i].v, vt[i].a, vt[i].d, vt[i].c, 0);
      chk($sformatf("vec%0d.wr_sel", i), int'(wr_sel), vt[i].sel);
      chk($sformatf("vec%0d.wr_din", i), int'(wr_din), vt[i].din);
      chk($sformatf("vec%0d.count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d.req_ready", i), int'(req_ready), vt[i].rdy);
      chk($sformatf("vec%0d.busy", i), int'(busy), vt[i].bsy);
      chk($sformatf("vec%0d.err_addr", i), int'(err_addr), vt[i].err);
    end

    // Fill to full during a clear, then drain in order.
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 1, 1);
    step(1, 1, 1, 2, 0, 1);
    step(1, 1, 2, 3, 0, 1);
    step(1, 1, 1, 4, 0, 1);
    chk("full.count", int'(count), 4);
    chk("full.req_ready", int'(req_ready), 0);
    chk("full.last_clear_sel", int'(wr_sel), 4);
    step(1, 1, 0, 7, 0, 1);
    chk("full.refused_push_count", int'(count), 3);
    idle(4);
    chk("full.drained_count", int'(count), 0);

    // clr_start with two queued: clear runs first, busy held, queue follows.
    step(1, 1, 2, 6, 0, 1);
    step(1, 1, 0, 5, 1, 1);
    chk("clrq.count", int'(count), 2);
    for (int i = 0; i < NREG; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk($sformatf("clrq.sel%0d", i), int'(wr_sel), 1 << i);
      chk($sformatf("clrq.busy%0d", i), int'(busy), 1);
    end
    idle(3);

    // Reset in the middle of a clear with three queued.
    step(1, 1, 1, 1, 1, 1);
    step(1, 1, 2, 2, 0, 1);
    step(1, 1, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rstclr.count", int'(count), 0);
    chk("rstclr.sel", int'(wr_sel), 0);
    idle(5);
    chk("rstclr.busy", int'(busy), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 11) == 0), 1);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
